// File: rtl/monolith_round_seq.sv
// monolith_round_seq: takes one state from upstream, drives it through NUM_ROUNDS
// calls of an external round datapath, then offers the result downstream.
// A sticky err flag records stray round results and round-datapath timeouts.
module monolith_round_seq #(
  parameter int WORD_WIDTH   = 31,
  parameter int STATE_SIZE   = 16,
  parameter int NUM_ROUNDS   = 6,
  parameter int RC_IDX_WIDTH = 3,
  parameter int TIMEOUT      = 255
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] state_in,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] state_out,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] round_state,
  output logic                                  round_valid,
  output logic                                  round_pre,
  output logic [RC_IDX_WIDTH-1:0]               rc_index,
  input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] round_result,
  input  logic                                  round_result_valid,
  output logic                                  err
);

  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]         TO_LAST    = TO_W'(TIMEOUT - 1);
  localparam logic [RC_IDX_WIDTH-1:0] LAST_ROUND = RC_IDX_WIDTH'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                                r_state;
  state_t                                w_next;
  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] r_work;
  logic [RC_IDX_WIDTH-1:0]               r_roundCnt;
  logic [TO_W-1:0]                       r_timeout;
  logic                                  r_err;
  logic                                  w_accept;
  logic                                  w_resultTake;
  logic                                  w_lastRound;
  logic                                  w_timeoutHit;
  logic                                  w_spurious;

  // The working register feeds both the round datapath and the downstream port,
  // and the round counter doubles as the registered round-constant address.
  assign state_out   = r_work;
  assign round_state = r_work;
  assign rc_index    = r_roundCnt;
  assign err         = r_err;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode plus the handshake and launch outputs, all decoded from state.
  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_resultTake = 1'b0;
    w_timeoutHit = 1'b0;
    w_lastRound  = (r_roundCnt == LAST_ROUND);
    w_spurious   = round_result_valid && (r_state != WAIT);
    in_ready     = (r_state == IDLE);
    out_valid    = (r_state == DONE);
    round_valid  = (r_state == ISSUE);
    round_pre    = (r_roundCnt == '0) && ((r_state == ISSUE) || (r_state == WAIT));
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = ISSUE;
        end
      end
      ISSUE: begin
        w_next = WAIT;
      end
      WAIT: begin
        if (round_result_valid) begin
          w_resultTake = 1'b1;
          w_next       = w_lastRound ? DONE : ISSUE;
        end else if (r_timeout == TO_LAST) begin
          w_timeoutHit = 1'b1;
          w_next       = IDLE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Working state, round counter, timeout counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_work     <= '0;
      r_roundCnt <= '0;
      r_timeout  <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_work     <= state_in;
        r_roundCnt <= '0;
      end
      if (r_state == ISSUE) begin
        r_timeout <= '0;
      end else if ((r_state == WAIT) && !round_result_valid) begin
        r_timeout <= r_timeout + TO_W'(1);
      end
      if (w_resultTake) begin
        r_work <= round_result;
        if (!w_lastRound) begin
          r_roundCnt <= r_roundCnt + RC_IDX_WIDTH'(1);
        end
      end
      if (w_spurious || w_timeoutHit) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_monolith_round_seq.sv
// tb_monolith_round_seq: drives monolith_round_seq against a stub round datapath
// (latency 6, adds rc_index+1 to every word) and scores results from a queue.
module tb_monolith_round_seq;

  localparam int WW      = 31;
  localparam int SS      = 16;
  localparam int NR      = 6;
  localparam int RCW     = 3;
  localparam int TO      = 255;
  localparam int STUB_L  = 6;
  localparam int LATENCY = NR * (1 + STUB_L) + 1;

  typedef logic [SS-1:0][WW-1:0] vec_t;

  logic           clk = 1'b0;
  logic           reset;
  vec_t           state_in;
  logic           in_valid;
  logic           in_ready;
  vec_t           state_out;
  logic           out_valid;
  logic           out_ready;
  vec_t           round_state;
  logic           round_valid;
  logic           round_pre;
  logic [RCW-1:0] rc_index;
  vec_t           round_result;
  logic           round_result_valid;
  logic           err;

  int   checks     = 0;
  int   failures   = 0;
  vec_t expQ[$];
  bit   stubEnable = 1'b1;
  int   spurReq    = 0;
  int   spurDone   = 0;

  monolith_round_seq #(
    .WORD_WIDTH(WW), .STATE_SIZE(SS), .NUM_ROUNDS(NR), .RC_IDX_WIDTH(RCW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .state_in(state_in), .in_valid(in_valid), .in_ready(in_ready),
    .state_out(state_out), .out_valid(out_valid), .out_ready(out_ready),
    .round_state(round_state), .round_valid(round_valid), .round_pre(round_pre),
    .rc_index(rc_index), .round_result(round_result),
    .round_result_valid(round_result_valid), .err(err)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  // Reference permutation: round k adds k+1 to every word, wrapping at WW bits.
  function automatic vec_t model(input vec_t s);
    vec_t r;
    r = s;
    for (int k = 0; k < NR; k++)
      for (int w = 0; w < SS; w++)
        r[w] = r[w] + WW'(k + 1);
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int w = 0; w < SS; w++) v[w] = WW'($urandom);
    return v;
  endfunction

  // Stub round datapath: result appears STUB_L cycles after the launch strobe,
  // computed from the rc_index seen at launch; also injects stray results on request.
  initial begin : stub
    int   cnt;
    bit   pending;
    vec_t res;
    cnt = 0; pending = 1'b0; res = '0;
    round_result_valid = 1'b0;
    round_result = '0;
    forever begin
      @(negedge clk);
      round_result_valid = 1'b0;
      if (reset) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          cnt--;
          if (cnt == 0) begin
            round_result_valid = 1'b1;
            round_result = res;
            pending = 1'b0;
          end
        end
        if (round_valid && stubEnable) begin
          pending = 1'b1;
          cnt = STUB_L;
          for (int w = 0; w < SS; w++) res[w] = round_state[w] + WW'(rc_index) + WW'(1);
        end
      end
      if (spurReq != spurDone) begin
        round_result_valid = 1'b1;
        for (int w = 0; w < SS; w++) round_result[w] = WW'(32'h1234_5678 + w);
        spurDone++;
      end
    end
  end

  // Hard stop in case something wedges the sequence of tests.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  // Presents s until accepted (bounded); records the expected result when track is set.
  task automatic send_state(input vec_t s, input bit track, output bit ok);
    int guard;
    guard = 0;
    state_in = s;
    in_valid = 1'b1;
    while (!in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    ok = in_ready;
    if (ok && track) expQ.push_back(model(s));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    do_reset(3);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (round_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_round_valid got=%b exp=0", round_valid); end
    checks++; if (round_pre !== 1'b0) begin failures++; $display("[TB] FAIL reset_round_pre got=%b exp=0", round_pre); end
    checks++; if (rc_index !== '0) begin failures++; $display("[TB] FAIL reset_rc_index got=%0d exp=0", rc_index); end
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b exp=0", err); end
    checks++; if (state_out !== '0) begin failures++; $display("[TB] FAIL reset_state_out got=%h exp=0", state_out); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_release_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    bit ok;
    int lat;
    vec_t exp;
    send_state('0, 1'b1, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL basic_accept got=0 exp=1"); end
    lat = 0;
    for (int cyc = 1; cyc <= LATENCY + 20; cyc++) begin
      if (out_valid) begin lat = cyc; break; end
      @(negedge clk);
    end
    checks++; if (lat != LATENCY) begin failures++; $display("[TB] FAIL basic_latency got=%0d exp=%0d", lat, LATENCY); end
    checks++;
    if (out_valid === 1'b1 && expQ.size() > 0) begin
      exp = expQ.pop_front();
      if (state_out !== exp) begin failures++; $display("[TB] FAIL basic_data got=%h exp=%h", state_out, exp); end
    end else begin
      failures++; $display("[TB] FAIL basic_no_output got=%b exp=1", out_valid);
    end
    checks++; if (state_out[SS-1] !== WW'(21)) begin failures++; $display("[TB] FAIL basic_word21 got=%0d exp=21", state_out[SS-1]); end
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL basic_err got=%b exp=0", err); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_return_idle got=%b%b exp=10", in_ready, out_valid); end
  endtask

  task automatic test_rc_sequence();
    bit ok;
    bit prevRv;
    bit gotOut;
    int pulses;
    vec_t exp;
    send_state(rand_vec(), 1'b1, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL rc_accept got=0 exp=1"); end
    pulses = 0; prevRv = 1'b0; gotOut = 1'b0;
    for (int cyc = 1; cyc <= LATENCY + 20; cyc++) begin
      if (out_valid) begin gotOut = 1'b1; break; end
      checks++;
      if (round_valid) begin
        if (prevRv || rc_index !== RCW'(pulses) || round_pre !== (pulses == 0)) begin
          failures++;
          $display("[TB] FAIL rc_launch cyc=%0d got idx=%0d pre=%b exp idx=%0d pre=%b single=1", cyc, rc_index, round_pre, pulses, pulses == 0);
        end
        pulses++;
      end else if (rc_index !== RCW'(pulses - 1) || round_pre !== (pulses == 1)) begin
        failures++;
        $display("[TB] FAIL rc_hold cyc=%0d got idx=%0d pre=%b exp idx=%0d pre=%b", cyc, rc_index, round_pre, pulses - 1, pulses == 1);
      end
      prevRv = round_valid;
      @(negedge clk);
    end
    checks++; if (pulses != NR) begin failures++; $display("[TB] FAIL rc_pulse_count got=%0d exp=%0d", pulses, NR); end
    checks++;
    if (gotOut && expQ.size() > 0) begin
      exp = expQ.pop_front();
      if (state_out !== exp) begin failures++; $display("[TB] FAIL rc_data got=%h exp=%h", state_out, exp); end
    end else begin
      failures++; $display("[TB] FAIL rc_no_output got=%b exp=1", gotOut);
    end
    checks++; if (round_pre !== 1'b0) begin failures++; $display("[TB] FAIL rc_pre_done got=%b exp=0", round_pre); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit ok;
    int g;
    vec_t s2;
    vec_t exp1;
    vec_t exp;
    out_ready = 1'b0;
    s2 = rand_vec();
    send_state(rand_vec(), 1'b1, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL bp_accept got=0 exp=1"); end
    g = 0;
    while (!out_valid && g < LATENCY + 20) begin @(negedge clk); g++; end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_out_valid got=%b exp=1", out_valid); end
    exp1 = (expQ.size() > 0) ? expQ[0] : '0;
    state_in = s2;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || state_out !== exp1) begin
        failures++;
        $display("[TB] FAIL bp_hold_%0d got ov=%b ir=%b data=%h exp ov=1 ir=0 data=%h", i, out_valid, in_ready, state_out, exp1);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    checks++;
    if (expQ.size() > 0) begin
      exp = expQ.pop_front();
      if (state_out !== exp || out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_release got=%h exp=%h", state_out, exp); end
    end else begin
      failures++; $display("[TB] FAIL bp_release_empty got=0 exp=1");
    end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle got=%b%b exp=10", in_ready, out_valid); end
    expQ.push_back(model(s2));
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || round_valid !== 1'b1 || round_pre !== 1'b1 || rc_index !== '0) begin
      failures++;
      $display("[TB] FAIL b2b_issue got ir=%b rv=%b pre=%b idx=%0d exp 0 1 1 0", in_ready, round_valid, round_pre, rc_index);
    end
    g = 1;
    while (!out_valid && g < LATENCY + 20) begin @(negedge clk); g++; end
    checks++; if (g != LATENCY) begin failures++; $display("[TB] FAIL b2b_latency got=%0d exp=%0d", g, LATENCY); end
    checks++;
    if (out_valid === 1'b1 && expQ.size() > 0) begin
      exp = expQ.pop_front();
      if (state_out !== exp) begin failures++; $display("[TB] FAIL b2b_data got=%h exp=%h", state_out, exp); end
    end else begin
      failures++; $display("[TB] FAIL b2b_no_output got=%b exp=1", out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok;
    bit sawOut;
    stubEnable = 1'b0;
    send_state(rand_vec(), 1'b0, ok);
    checks++; if (!ok || round_valid !== 1'b1) begin failures++; $display("[TB] FAIL to_launch got ok=%b rv=%b exp 1 1", ok, round_valid); end
    sawOut = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      if (out_valid) sawOut = 1'b1;
      if (k == 255) begin
        checks++; if (err !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("[TB] FAIL to_before got err=%b ir=%b exp 0 0", err, in_ready); end
      end
      if (k == 256) begin
        checks++; if (err !== 1'b1 || in_ready !== 1'b1) begin failures++; $display("[TB] FAIL to_fired got err=%b ir=%b exp 1 1", err, in_ready); end
      end
    end
    checks++; if (sawOut) begin failures++; $display("[TB] FAIL to_out_valid got=1 exp=0"); end
    repeat (3) @(negedge clk);
    checks++; if (err !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL to_sticky got err=%b ir=%b ov=%b exp 1 1 0", err, in_ready, out_valid); end
    stubEnable = 1'b1;
    do_reset(2);
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL to_reset_clears got=%b exp=0", err); end
  endtask

  task automatic test_spurious();
    bit ok;
    int g;
    vec_t exp;
    @(posedge clk);
    spurReq++;
    @(negedge clk);
    @(negedge clk);
    checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL sp_err got=%b exp=1", err); end
    checks++; if (state_out !== '0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL sp_ignored got=%h ir=%b exp=0 ir=1", state_out, in_ready); end
    send_state('0, 1'b1, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL sp_accept got=0 exp=1"); end
    g = 1;
    while (!out_valid && g < LATENCY + 20) begin @(negedge clk); g++; end
    checks++; if (g != LATENCY) begin failures++; $display("[TB] FAIL sp_latency got=%0d exp=%0d", g, LATENCY); end
    checks++;
    if (out_valid === 1'b1 && expQ.size() > 0) begin
      exp = expQ.pop_front();
      if (state_out !== exp) begin failures++; $display("[TB] FAIL sp_data got=%h exp=%h", state_out, exp); end
    end else begin
      failures++; $display("[TB] FAIL sp_no_output got=%b exp=1", out_valid);
    end
    checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL sp_err_sticky got=%b exp=1", err); end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    bit ok;
    int g;
    vec_t exp;
    send_state(rand_vec(), 1'b1, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL mid_accept got=0 exp=1"); end
    g = 0;
    while (!(round_valid === 1'b1 && rc_index === RCW'(3)) && g < LATENCY) begin @(negedge clk); g++; end
    checks++; if (round_valid !== 1'b1 || rc_index !== RCW'(3)) begin failures++; $display("[TB] FAIL mid_round3_issue got rv=%b idx=%0d exp 1 3", round_valid, rc_index); end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rc_index !== RCW'(3) || round_pre !== 1'b0 || round_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("[TB] FAIL mid_round3_wait got idx=%0d pre=%b rv=%b ir=%b exp 3 0 0 0", rc_index, round_pre, round_valid, in_ready);
    end
    reset = 1'b1;
    @(negedge clk);
    expQ.delete();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || round_valid !== 1'b0 || round_pre !== 1'b0) begin
      failures++; $display("[TB] FAIL mid_reset_ctrl got ir=%b ov=%b rv=%b pre=%b exp 1 0 0 0", in_ready, out_valid, round_valid, round_pre);
    end
    checks++; if (rc_index !== '0 || err !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_regs got idx=%0d err=%b exp 0 0", rc_index, err); end
    checks++; if (state_out !== '0) begin failures++; $display("[TB] FAIL mid_reset_data got=%h exp=0", state_out); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_post_ready got=%b%b exp=10", in_ready, out_valid); end
    send_state(rand_vec(), 1'b1, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL mid_reaccept got=0 exp=1"); end
    g = 1;
    while (!out_valid && g < LATENCY + 20) begin @(negedge clk); g++; end
    checks++; if (g != LATENCY) begin failures++; $display("[TB] FAIL mid_latency got=%0d exp=%0d", g, LATENCY); end
    checks++;
    if (out_valid === 1'b1 && expQ.size() > 0) begin
      exp = expQ.pop_front();
      if (state_out !== exp) begin failures++; $display("[TB] FAIL mid_data got=%h exp=%h", state_out, exp); end
    end else begin
      failures++; $display("[TB] FAIL mid_no_output got=%b exp=1", out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    bit ok;
    int g;
    vec_t s;
    vec_t exp;
    for (int t = 0; t < 3; t++) begin
      s = (t == 0) ? '1 : rand_vec();
      send_state(s, 1'b1, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL rnd_accept_%0d got=0 exp=1", t); end
      g = 1;
      while (!out_valid && g < LATENCY + 20) begin @(negedge clk); g++; end
      checks++;
      if (out_valid === 1'b1 && expQ.size() > 0) begin
        exp = expQ.pop_front();
        if (state_out !== exp) begin failures++; $display("[TB] FAIL rnd_data_%0d got=%h exp=%h", t, state_out, exp); end
      end else begin
        failures++; $display("[TB] FAIL rnd_no_output_%0d got=%b exp=1", t, out_valid);
      end
      if (t == 0) begin
        checks++; if (state_out[0] !== WW'(20)) begin failures++; $display("[TB] FAIL rnd_wrap got=%0d exp=20", state_out[0]); end
      end
    end
  endtask

  // Test sequence.
  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    state_in = '0;
    test_reset();
    test_basic();
    test_rc_sequence();
    test_backpressure();
    test_timeout();
    test_spurious();
    test_reset_midrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/monolith_round_seq.md
MONOLITH_ROUND_SEQ -- requirements
Module: monolith_round_seq

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 31, field element width in bits.
REQ-002 SHALL have parameter STATE_SIZE, default 16, words per state.
REQ-003 SHALL have parameter NUM_ROUNDS, default 6, rounds applied per permutation call.
REQ-004 SHALL have parameter RC_IDX_WIDTH, default 3, width of round-constant index; 2**RC_IDX_WIDTH >= NUM_ROUNDS.
REQ-005 SHALL have parameter TIMEOUT, default 255, maximum cycles waited for one round result.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port state_in  input  [WORD_WIDTH-1:0] x STATE_SIZE  upstream state.
REQ-009 SHALL have port in_valid  input  1  upstream state valid.
REQ-010 SHALL have port in_ready  output  1  block accepts a new state.
REQ-011 SHALL have port state_out  output  [WORD_WIDTH-1:0] x STATE_SIZE  permuted state.
REQ-012 SHALL have port out_valid  output  1  state_out valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts state_out.
REQ-014 SHALL have port round_state  output  [WORD_WIDTH-1:0] x STATE_SIZE  state to round datapath.
REQ-015 SHALL have port round_valid  output  1  one-cycle launch strobe to round datapath.
REQ-016 SHALL have port round_pre  output  1  pre-round flag to round datapath.
REQ-017 SHALL have port rc_index  output  RC_IDX_WIDTH  round-constant ROM address for the round in flight.
REQ-018 SHALL have port round_result  input  [WORD_WIDTH-1:0] x STATE_SIZE  state returned by round datapath.
REQ-019 SHALL have port round_result_valid  input  1  round_result valid, one-cycle strobe.
REQ-020 SHALL have port err  output  1  sticky protocol/timeout error.

Function
REQ-021 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE; in_ready = (state==IDLE), out_valid = (state==DONE), both combinational from state.
REQ-022 IDLE: on in_valid, SHALL register state_in into a working register, clear round counter to 0, go to ISSUE.
REQ-023 ISSUE: SHALL assert round_valid for exactly one cycle with round_state = working register, go to WAIT, clear timeout counter.
REQ-024 round_pre SHALL be 1 exactly while round counter == 0 and state is ISSUE or WAIT, else 0.
REQ-025 rc_index SHALL equal round counter, registered, and SHALL remain stable from the ISSUE cycle until the cycle round_result_valid is sampled (round datapath applies constants late in its pipeline).
REQ-026 WAIT: on round_result_valid, SHALL load round_result into working register; if counter == NUM_ROUNDS-1 go to DONE, else increment counter and go to ISSUE.
REQ-027 WAIT: timeout counter increments each cycle; on reaching TIMEOUT without round_result_valid, SHALL set err and go to IDLE, discarding the state.
REQ-028 DONE: state_out SHALL equal working register and stay stable while out_valid && !out_ready; on out_ready go to IDLE.
REQ-029 round_result_valid in any state other than WAIT SHALL be ignored (no register update) and SHALL set err.
REQ-030 in_valid outside IDLE SHALL be ignored; the upstream holds it until in_ready.
REQ-031 Latency in_valid&&in_ready to out_valid SHALL be NUM_ROUNDS*(1+L) + 1 cycles, L = round datapath latency from round_valid to round_result_valid.
REQ-032 Back-to-back: out_ready in DONE and in_valid in following IDLE cycle SHALL both be accepted; at most one permutation in flight.
REQ-033 No arithmetic on state words; width of every state word preserved bit-exact.

Reset
REQ-034 While reset is high at a clock edge: state=IDLE, counters 0, working register 0, round_valid 0, round_pre 0, rc_index 0, err 0, state_out 0.
REQ-035 Reset mid-permutation SHALL abort without emitting out_valid; in_ready = 1 in the first cycle after reset deasserts.
REQ-036 err SHALL clear only on reset.

Verification
REQ-037 Stub round (L=6, each word += rc_index+1); state_in all 0 -> out_valid after 6*7+1=43 cycles, every state_out word = 21, err 0.
REQ-038 Same stub, out_ready held 0 for 10 cycles in DONE -> state_out stable, in_ready 0, accepted on 11th cycle, then IDLE.
REQ-039 Check rc_index sequence 0..5 each stable across its full round; round_pre high only during round 0; round_valid exactly 6 one-cycle pulses.
REQ-040 Stub never returns result -> err=1 after TIMEOUT=255 WAIT cycles, FSM back to IDLE, no out_valid.
REQ-041 Spurious round_result_valid in IDLE -> err=1, working register unchanged; next permutation with stub still yields 21 per word.
REQ-042 Reset asserted in round 3 WAIT -> all outputs at reset values next cycle; new permutation afterwards completes correctly.
